// File: rtl/spi_frame_slave.sv
// Serial frame target: decodes config/start/read frames, holds the config register, returns read data.
// Latency: commit and error pulses are registered on the detecting edge; read bit i is launched i+1 cycles after the header.
// Backpressure: with SPI_SUSPEND_EN defined, a 2-cycle suspend stalls header/payload sampling; otherwise suspend is tied 0.
module spi_frame_slave #(
  parameter logic [7:0] CFG_HDR   = 8'h5A,
  parameter logic [7:0] START_HDR = 8'h3C,
  parameter logic [7:0] READ_HDR  = 8'hC3,
  parameter logic [7:0] CFG_RST   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame,
  inout  wire        serial,
  output logic       suspend,
  input  logic       suspend_on,
  output logic [7:0] cfg_data,
  output logic       cfg_wr,
  output logic       start,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CFG, S_TURN, S_RDAT, S_END, S_WAIT
  } state_t;

  typedef enum logic [1:0] {
    T_CFG, T_START, T_READ
  } txn_t;

  state_t     state;
  txn_t       txn;
  logic [3:0] cnt;
  logic [7:0] shreg;
  logic       ser_oe;
  logic       ser_dat;
  logic       samp;
  logic [7:0] shreg_nxt;

  assign serial    = ser_oe ? ser_dat : 1'bz;
  assign samp      = ~suspend;
  assign shreg_nxt = {serial, shreg[7:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      txn       <= T_CFG;
      cnt       <= 4'd0;
      shreg     <= 8'h00;
      ser_oe    <= 1'b0;
      ser_dat   <= 1'b0;
      cfg_data  <= CFG_RST;
      cfg_wr    <= 1'b0;
      start     <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      cfg_wr    <= 1'b0;
      start     <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt    <= 4'd0;
          ser_oe <= 1'b0;
          if (frame) state <= S_HDR;
        end
        S_HDR, S_CFG: begin
          if (!frame) begin
            err_pulse <= 1'b1;
            err_code  <= 2'b01;
            cnt       <= 4'd0;
            state     <= S_IDLE;
          end else if (samp) begin
            shreg <= shreg_nxt;
            if (cnt == 4'd7) begin
              cnt <= 4'd0;
              if (state == S_CFG) begin
                state <= S_END;
              end else if (shreg_nxt == CFG_HDR) begin
                txn   <= T_CFG;
                state <= S_CFG;
              end else if (shreg_nxt == START_HDR) begin
                txn   <= T_START;
                state <= S_END;
              end else if (shreg_nxt == READ_HDR) begin
                txn   <= T_READ;
                state <= S_TURN;
              end else begin
                err_pulse <= 1'b1;
                err_code  <= 2'b11;
                state     <= S_WAIT;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_TURN: begin
          if (!frame) begin
            err_pulse <= 1'b1;
            err_code  <= 2'b01;
            state     <= S_IDLE;
          end else begin
            ser_oe  <= 1'b1;
            ser_dat <= cfg_data[0];
            cnt     <= 4'd1;
            state   <= S_RDAT;
          end
        end
        S_RDAT: begin
          if (!frame) begin
            err_pulse <= 1'b1;
            err_code  <= 2'b01;
            ser_oe    <= 1'b0;
            cnt       <= 4'd0;
            state     <= S_IDLE;
          end else if (cnt == 4'd9) begin
            // parity bit stays on the wire until the frame closes
            cnt   <= 4'd0;
            state <= S_END;
          end else begin
            ser_dat <= (cnt == 4'd8) ? ^cfg_data : cfg_data[cnt[2:0]];
            cnt     <= cnt + 4'd1;
          end
        end
        S_END: begin
          ser_oe <= 1'b0;
          if (!frame) begin
            if (txn == T_CFG) begin
              cfg_data <= shreg;
              cfg_wr   <= 1'b1;
            end
            if (txn == T_START) start <= 1'b1;
            state <= S_IDLE;
          end else begin
            err_pulse <= 1'b1;
            err_code  <= 2'b10;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          ser_oe <= 1'b0;
          if (!frame) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_SUSPEND_EN
  logic [7:0] lfsr;
  logic       susp_left;
  logic       bits_remain;

  // a stall is only useful if another header/payload bit is still to come
  assign bits_remain = frame && (state == S_HDR || state == S_CFG) &&
                       !(samp && cnt == 4'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr      <= 8'hA5;
      suspend   <= 1'b0;
      susp_left <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (suspend) begin
        if (!frame || !(state == S_HDR || state == S_CFG)) begin
          suspend   <= 1'b0;
          susp_left <= 1'b0;
        end else if (susp_left) begin
          susp_left <= 1'b0;
        end else begin
          suspend <= 1'b0;
        end
      end else if (suspend_on && bits_remain && lfsr[2:0] == 3'd0) begin
        suspend   <= 1'b1;
        susp_left <= 1'b1;
      end
    end
  end
`else
  wire unused_suspend_on = suspend_on;
  assign suspend = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: acts as link master, checks commits, read-back and error codes.
module tb_spi_frame_slave;

  logic       clk;
  logic       rst;
  logic       frame;
  logic       suspend_on;
  logic       m_oe;
  logic       m_dat;
  wire        serial;
  logic       suspend;
  logic [7:0] cfg_data;
  logic       cfg_wr;
  logic       start;
  logic       err_pulse;
  logic [1:0] err_code;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  assign serial = m_oe ? m_dat : 1'bz;

  spi_frame_slave dut (
    .clk        (clk),
    .rst        (rst),
    .frame      (frame),
    .serial     (serial),
    .suspend    (suspend),
    .suspend_on (suspend_on),
    .cfg_data   (cfg_data),
    .cfg_wr     (cfg_wr),
    .start      (start),
    .err_pulse  (err_pulse),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (err_pulse) err_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one bit per unsuspended edge; suspend seen now governs the next edge
  task automatic send_bit(input logic b);
    logic s;
    int   n;
    n     = 0;
    m_dat = b;
    do begin
      s = suspend;
      tick();
      n++;
    end while (s && n < 16);
    if (s) begin
      checks++;
      failures++;
      $display("FAIL suspend_timeout: got stalled %0d cycles expected release", n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic begin_frame();
    frame = 1'b1;
    m_oe  = 1'b1;
    m_dat = 1'b0;
    tick();
  endtask

  task automatic cfg_frame(input logic [7:0] val, input string name);
    int e0;
    e0 = err_seen;
    begin_frame();
    send_byte(8'h5A);
    send_byte(val);
    chk({name, "_cfg_wr_early"}, {8'h0, cfg_wr}, 9'h0);
    frame = 1'b0;
    tick();
    chk({name, "_cfg_wr"}, {8'h0, cfg_wr}, 9'h1);
    chk({name, "_cfg_data"}, {1'b0, cfg_data}, {1'b0, val});
    tick();
    chk({name, "_cfg_wr_single"}, {8'h0, cfg_wr}, 9'h0);
    chk({name, "_no_err"}, 9'(err_seen - e0), 9'h0);
  endtask

  task automatic test_reset();
    rst = 1'b0; frame = 1'b0; m_oe = 1'b0; m_dat = 1'b0; suspend_on = 1'b0;
    repeat (3) tick();
    chk("rst_suspend", {8'h0, suspend}, 9'h0);
    chk("rst_cfg_data", {1'b0, cfg_data}, 9'h000);
    chk("rst_cfg_wr", {8'h0, cfg_wr}, 9'h0);
    chk("rst_start", {8'h0, start}, 9'h0);
    chk("rst_err_pulse", {8'h0, err_pulse}, 9'h0);
    chk("rst_err_code", {7'h0, err_code}, 9'h0);
    chk("rst_oe", {8'h0, dut.ser_oe}, 9'h0);
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_config();
    cfg_frame(8'h02, "config");
  endtask

  task automatic test_start();
    begin_frame();
    send_byte(8'h3C);
    frame = 1'b0;
    tick();
    chk("start_pulse", {8'h0, start}, 9'h1);
    chk("start_cfg_kept", {1'b0, cfg_data}, 9'h002);
    tick();
    chk("start_single", {8'h0, start}, 9'h0);
  endtask

  task automatic test_read();
    logic [8:0] rd;
    int         oe_bad;
    int         e0;
    e0     = err_seen;
    oe_bad = 0;
    rd     = '0;
    begin_frame();
    send_byte(8'hC3);
    m_oe = 1'b0;
    chk("read_turn_z", {8'h0, dut.ser_oe}, 9'h0);
    tick();
    for (int i = 0; i < 9; i++) begin
      if (dut.ser_oe !== 1'b1) oe_bad++;
      rd[i] = serial;
      tick();
    end
    chk("read_hold_bit8", {8'h0, serial}, 9'h1);
    frame = 1'b0;
    tick();
    chk("read_data", {1'b0, rd[7:0]}, 9'h002);
    chk("read_parity", {8'h0, rd[8]}, 9'h1);
    chk("read_oe_during", 9'(oe_bad), 9'h0);
    chk("read_release", {8'h0, dut.ser_oe}, 9'h0);
    chk("read_no_err", 9'(err_seen - e0), 9'h0);
  endtask

  task automatic test_short();
    begin_frame();
    send_byte(8'h5A);
    frame = 1'b0;
    tick();
    chk("short_pulse", {8'h0, err_pulse}, 9'h1);
    chk("short_code", {7'h0, err_code}, 9'h001);
    chk("short_no_wr", {8'h0, cfg_wr}, 9'h0);
    tick();
    chk("short_cfg_kept", {1'b0, cfg_data}, 9'h002);
  endtask

  task automatic test_long();
    begin_frame();
    send_byte(8'h3C);
    tick();
    chk("long_pulse", {8'h0, err_pulse}, 9'h1);
    chk("long_code", {7'h0, err_code}, 9'h002);
    chk("long_no_start", {8'h0, start}, 9'h0);
    frame = 1'b0;
    tick();
    chk("long_no_start_late", {8'h0, start}, 9'h0);
  endtask

  task automatic test_back_to_back();
    begin_frame();
    send_byte(8'h3C);
    frame = 1'b0;
    tick();
    chk("b2b_start", {8'h0, start}, 9'h1);
    chk("b2b_code_held", {7'h0, err_code}, 9'h002);
  endtask

  task automatic test_bad_header();
    begin_frame();
    send_byte(8'h00);
    chk("bad_pulse", {8'h0, err_pulse}, 9'h1);
    chk("bad_code", {7'h0, err_code}, 9'h003);
    repeat (3) tick();
    frame = 1'b0;
    tick();
    chk("bad_no_wr", {8'h0, cfg_wr}, 9'h0);
    chk("bad_cfg_kept", {1'b0, cfg_data}, 9'h002);
    chk("bad_code_held", {7'h0, err_code}, 9'h003);
  endtask

  task automatic test_suspend();
    suspend_on = 1'b1;
    cfg_frame(8'hB4, "susp1");
    cfg_frame(8'h02, "susp2");
    chk("susp_idle_low", {8'h0, suspend}, 9'h0);
    suspend_on = 1'b0;
  endtask

  task automatic test_async_reset();
    begin_frame();
    send_byte(8'h5A);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b0;
    #2;
    chk("arst_cfg_data", {1'b0, cfg_data}, 9'h000);
    chk("arst_code", {7'h0, err_code}, 9'h000);
    frame = 1'b0;
    m_oe  = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("arst_no_wr", {8'h0, cfg_wr}, 9'h0);
    chk("arst_discard", {1'b0, cfg_data}, 9'h000);
  endtask

  initial begin
    test_reset();
    test_config();
    test_start();
    test_read();
    test_short();
    test_long();
    test_back_to_back();
    test_bad_header();
    test_suspend();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
